// File: rtl/ins_rom_ctrl.sv
// ins_rom_ctrl: writable instruction store with post-reset clear, program port and 1-cycle valid/ready fetch; `define PARITY_EN adds per-word even parity and the par_inj port
module ins_rom_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 12,
  parameter int DEPTH = 2048,
  parameter logic [DATA_W-1:0] CLR_WORD = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
`ifdef PARITY_EN
  input  logic              par_inj,
`endif
  output logic              busy
);
`ifdef PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_n;
  logic [ADDR_W:0] cnt, cnt_n;
  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] wword, rword;
  logic [DATA_W-1:0] wdata;
  logic [IW-1:0] waddr;
  logic accept, req_in, prog_in, we, rerr;
  assign req_in = {1'b0, req_addr} < DEPTH_C;
  assign prog_in = {1'b0, prog_addr} < DEPTH_C;
  assign accept = req_valid && req_ready;
  assign rword = mem[req_addr[IW-1:0]];
  // The clear sweep owns the single write port until RUN; program writes are dropped meanwhile
  assign we = (state == CLEAR) || (prog_we && prog_in);
  assign waddr = state == CLEAR ? cnt[IW-1:0] : prog_addr[IW-1:0];
  assign wdata = state == CLEAR ? CLR_WORD : prog_data;
`ifdef PARITY_EN
  assign wword = {(^wdata) ^ (state == RUN && par_inj), wdata};
  assign rerr = ^rword;
`else
  assign wword = wdata;
  assign rerr = 1'b0;
`endif
  // Controller state and clear counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= CLEAR;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  // Next state, clear progress and handshake outputs
  always_comb begin
    state_n = (state == CLEAR && cnt == DEPTH_C - 1'b1) ? RUN : state;
    cnt_n = state == CLEAR ? cnt + 1'b1 : cnt;
    busy = state == CLEAR;
    req_ready = state == RUN && (!rsp_valid || rsp_ready);
  end
  // Storage write; the fetch below samples the pre-write word on a same-edge collision
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wword;
  // Single-stage response register, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_data <= req_in ? rword[DATA_W-1:0] : '0;
      rsp_err <= !req_in || rerr;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
endmodule

// File: tb/tb_ins_rom_ctrl.sv
// tb_ins_rom_ctrl: directed bench for ins_rom_ctrl (DEPTH 2048 and DEPTH 1000 instances)
module tb_ins_rom_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, prog_we, busy;
  logic [10:0] req_addr, prog_addr;
  logic [11:0] rsp_data, prog_data;
  logic req_valid2, req_ready2, rsp_valid2, rsp_err2, prog_we2, busy2;
  logic [10:0] req_addr2, prog_addr2;
  logic [11:0] rsp_data2, prog_data2;
  logic par_inj;
  int checks = 0;
  int errors = 0;
  int nb, bad;

  always #5 clk = ~clk;

  ins_rom_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
`ifdef PARITY_EN
    .par_inj(par_inj),
`endif
    .busy(busy)
  );

  ins_rom_ctrl #(.DEPTH(1000)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2), .req_addr(req_addr2),
    .rsp_valid(rsp_valid2), .rsp_ready(1'b1), .rsp_data(rsp_data2), .rsp_err(rsp_err2),
    .prog_we(prog_we2), .prog_addr(prog_addr2), .prog_data(prog_data2),
`ifdef PARITY_EN
    .par_inj(1'b0),
`endif
    .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic wait_clear(input string tag);
    nb = 0;
    bad = 0;
    while (busy && nb < 3000) begin
      if (req_ready) bad++;
      nb++;
      nxt();
    end
    chk({tag, "_cycles"}, nb, 2048);
    chk({tag, "_ready_during_clear"}, bad, 0);
  endtask

  task automatic fetch2(input logic [10:0] a, input logic [11:0] d, input logic e);
    req_valid2 = 1'b1;
    req_addr2 = a;
    nxt();
    chk($sformatf("oor_valid_%0d", a), rsp_valid2, 1);
    chk($sformatf("oor_data_%0d", a), rsp_data2, d);
    chk($sformatf("oor_err_%0d", a), rsp_err2, e);
    req_valid2 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b1; req_addr = '0; rsp_ready = 1'b1;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0; par_inj = 1'b0;
    req_valid2 = 1'b0; req_addr2 = '0; prog_we2 = 1'b0; prog_addr2 = '0; prog_data2 = '0;
    nxt();
    nxt();
    chk("rst_busy", busy, 1);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    rst_n = 1'b1;
    wait_clear("clear");
    chk("run_req_ready", req_ready, 1);
    chk("run_no_early_rsp", rsp_valid, 0);
    nxt();
    req_valid = 1'b0;
    chk("first_valid", rsp_valid, 1);
    chk("first_data", rsp_data, 12'h000);
    chk("first_err", rsp_err, 0);
    chk("busy2_done", busy2, 0);
    prog_we = 1'b1;
    prog_addr = 11'd0; prog_data = 12'hA01; nxt();
    prog_addr = 11'd1; prog_data = 12'h063; nxt();
    prog_addr = 11'd2; prog_data = 12'h065; nxt();
    prog_addr = 11'd4; prog_data = 12'hCF8; nxt();
    prog_we = 1'b0;
    req_valid = 1'b1;
    req_addr = 11'd0; nxt();
    chk("b2b0_valid", rsp_valid, 1);
    chk("b2b0_data", rsp_data, 12'hA01);
    req_addr = 11'd1; nxt();
    chk("b2b1_valid", rsp_valid, 1);
    chk("b2b1_data", rsp_data, 12'h063);
    req_addr = 11'd2; nxt();
    chk("b2b2_valid", rsp_valid, 1);
    chk("b2b2_data", rsp_data, 12'h065);
    req_valid = 1'b0;
    nxt();
    chk("drain_valid", rsp_valid, 0);
    chk("drain_data_kept", rsp_data, 12'h065);
    req_valid = 1'b1; req_addr = 11'd1;
    nxt();
    chk("bp_first_data", rsp_data, 12'h063);
    rsp_ready = 1'b0; req_addr = 11'd2;
    #1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      nxt();
      if (rsp_valid !== 1'b1 || rsp_data !== 12'h063 || req_ready !== 1'b0) bad++;
    end
    chk("bp_stall_stable", bad, 0);
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", req_ready, 1);
    nxt();
    chk("bp_next_valid", rsp_valid, 1);
    chk("bp_next_data", rsp_data, 12'h065);
    req_addr = 11'd4; prog_we = 1'b1; prog_addr = 11'd4; prog_data = 12'h0F8;
    nxt();
    prog_we = 1'b0;
    chk("rfirst_old", rsp_data, 12'hCF8);
    nxt();
    chk("rfirst_new", rsp_data, 12'h0F8);
    req_valid = 1'b0;
    nxt();
    prog_we2 = 1'b1;
    prog_addr2 = 11'd5; prog_data2 = 12'h123; nxt();
    prog_addr2 = 11'd1500; prog_data2 = 12'h777; nxt();
    prog_we2 = 1'b0;
    fetch2(11'd5, 12'h123, 1'b0);
    fetch2(11'd1000, 12'h000, 1'b1);
    fetch2(11'd1500, 12'h000, 1'b1);
    fetch2(11'd476, 12'h000, 1'b0);
    fetch2(11'd999, 12'h000, 1'b0);
`ifdef PARITY_EN
    prog_we = 1'b1; prog_addr = 11'd9; prog_data = 12'h94E; par_inj = 1'b1;
    nxt();
    prog_we = 1'b0; par_inj = 1'b0; req_valid = 1'b1; req_addr = 11'd9;
    nxt();
    req_valid = 1'b0;
    chk("par_bad_data", rsp_data, 12'h94E);
    chk("par_bad_err", rsp_err, 1);
    prog_we = 1'b1;
    nxt();
    prog_we = 1'b0; req_valid = 1'b1;
    nxt();
    req_valid = 1'b0;
    chk("par_good_data", rsp_data, 12'h94E);
    chk("par_good_err", rsp_err, 0);
`endif
    req_valid = 1'b1; req_addr = 11'd0; rsp_ready = 1'b0;
    nxt();
    chk("mid_pending", rsp_valid, 1);
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_ready", req_ready, 0);
    nxt();
    rst_n = 1'b1; rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 11'd0;
    wait_clear("reclear");
    nxt();
    req_valid = 1'b0;
    chk("reclear_valid", rsp_valid, 1);
    chk("reclear_data", rsp_data, 12'h000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
